// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM state encoding
// and the helper that decides whether a request needs the iterative path.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // A shift by zero completes like a single-cycle op; MUL always iterates.
    function automatic logic is_multicycle(input logic [3:0] op, input logic shamt_nonzero);
        logic is_shift;
        is_shift = (op == OP_SRA) || (op == OP_SLL) || (op == OP_SRL);
        return (op == OP_MUL) || (is_shift && shamt_nonzero);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle datapath: logic ops, ADD/SUB with carry and signed overflow,
// zero-distance shifts (pass-through) and the illegal-op response.
module alu_mc_comb #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             err
);
    import alu_pkg::*;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // SUB is a + ~b + 1, so its carry out means "no borrow".
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        err      = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                cout     = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            // Shifts only arrive here with a zero shift amount.
            OP_SRA, OP_SLL, OP_SRL: result = a;
            OP_MUL: result = '0;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops finish at accept;
// shifts step one bit per cycle and MUL runs WIDTH shift-add iterations.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             err
);
    import alu_pkg::*;

    localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] ONE       = (SHW+1)'(1);

    state_t           state;
    logic [SHW:0]     count;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             multi;
    logic [WIDTH-1:0] comb_result;
    logic             comb_cout;
    logic             comb_overflow;
    logic             comb_err;

    assign shamt    = b[SHW-1:0];
    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign multi    = is_multicycle(op, |shamt);

    alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (comb_result),
        .cout     (comb_cout),
        .overflow (comb_overflow),
        .err      (comb_err)
    );

    // One iteration step: a single bit of shift, or one shift-add of the multiply.
    always_comb begin
        acc_next = acc;
        case (op_q)
            OP_SRA: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_SLL: acc_next = {acc[WIDTH-2:0], 1'b0};
            OP_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
            OP_MUL: if (mplier[0]) acc_next = acc + mcand;
            default: acc_next = acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            op_q      <= OP_AND;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
        end else if (accept) begin
            if (multi) begin
                state     <= S_BUSY;
                op_q      <= op;
                out_valid <= 1'b0;
                count     <= (op == OP_MUL) ? MUL_ITERS : {1'b0, shamt};
                acc       <= (op == OP_MUL) ? '0 : a;
                mcand     <= a;
                mplier    <= b;
            end else begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= comb_result;
                cout      <= comb_cout;
                overflow  <= comb_overflow;
                zero      <= (comb_result == '0);
                err       <= comb_err;
            end
        end else if (state == S_BUSY) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - ONE;
            // The last iteration lands its value straight in the output register.
            if (count == ONE) begin
                state     <= S_DONE;
                out_valid <= 1'b1;
                result    <= acc_next;
                cout      <= 1'b0;
                overflow  <= 1'b0;
                zero      <= (acc_next == '0);
                err       <= 1'b0;
            end
        end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: table-driven vectors through a scoreboard queue,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             err;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string what, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", what, got, want);
        end
    endtask

    task automatic checkBit(input string what, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b want %b", what, got, want);
        end
    endtask

    task automatic checkInt(input string what, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", what, got, want);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i, input logic [31:0] res, input logic c,
                                input logic v, input logic e, input int lat);
        vec_t x;
        x.name = name; x.op = op_i; x.a = a_i; x.b = b_i; x.res = res;
        x.cout = c; x.ovf = v; x.err = e; x.lat = lat;
        return x;
    endfunction

    function automatic exp_t toExp(input vec_t v);
        exp_t x;
        x.name = v.name; x.res = v.res; x.cout = v.cout; x.ovf = v.ovf;
        x.zero = (v.res == 32'h0); x.err = v.err; x.lat = v.lat;
        return x;
    endfunction

    // Drive one request at a falling edge, record its expectation, and return #1 after the accept edge.
    task automatic applyStimulus(input vec_t v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkBit({v.name, " in_ready before accept"}, in_ready, 1'b1);
        in_valid = 1'b1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        sb.push_back(toExp(v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then compare against the oldest expectation.
    task automatic checkOutput();
        exp_t x;
        int   cycles;
        int   busy_ready;
        cycles = 0;
        busy_ready = 0;
        x = sb.pop_front();
        while (!out_valid && cycles < 100) begin
            if (in_ready) busy_ready++;
            @(posedge clk);
            #1;
            cycles++;
        end
        checkBit({x.name, " out_valid"}, out_valid, 1'b1);
        checkVal({x.name, " result"}, result, x.res);
        checkBit({x.name, " cout"}, cout, x.cout);
        checkBit({x.name, " overflow"}, overflow, x.ovf);
        checkBit({x.name, " zero"}, zero, x.zero);
        checkBit({x.name, " err"}, err, x.err);
        checkInt({x.name, " latency"}, cycles, x.lat);
        if (x.lat > 0) checkInt({x.name, " in_ready while busy"}, busy_ready, 0);
    endtask

    initial begin
        in_valid  = 1'b0;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        reset     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkBit("reset out_valid", out_valid, 1'b0);
        checkVal("reset result", result, 32'h0);
        checkBit("reset cout", cout, 1'b0);
        checkBit("reset overflow", overflow, 1'b0);
        checkBit("reset zero", zero, 1'b0);
        checkBit("reset err", err, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkBit("in_ready after reset", in_ready, 1'b1);

        vecs.push_back(mk("add",        OP_ADD, 32'hC00000EA, 32'hF1E00000, 32'hB1E000EA, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk("sub",        OP_SUB, 32'hFF0000FF, 32'h71E0003E, 32'h8D2000C1, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk("add_ovf",    OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 0));
        vecs.push_back(mk("sub_eq",     OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 0));
        vecs.push_back(mk("sub_borrow", OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("sub_ovf",    OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 0));
        vecs.push_back(mk("and",        OP_AND, 32'hC0000000, 32'hC000001F, 32'hC0000000, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("or",         OP_OR,  32'hC00000FF, 32'hF1E00000, 32'hF1E000FF, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("xor",        OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("nor",        OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("sra3",       OP_SRA, 32'hC00000FF, 32'h00000003, 32'hF800001F, 1'b0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("sll3",       OP_SLL, 32'hC00000FF, 32'h00000003, 32'h000007F8, 1'b0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("srl3",       OP_SRL, 32'hC00000FF, 32'h00000003, 32'h1800001F, 1'b0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("sra0",       OP_SRA, 32'hC00000FF, 32'h00000000, 32'hC00000FF, 1'b0, 1'b0, 1'b0, 0));
        vecs.push_back(mk("sra_hibits", OP_SRA, 32'hC00000FF, 32'h00000023, 32'hF800001F, 1'b0, 1'b0, 1'b0, 3));
        vecs.push_back(mk("srl31",      OP_SRL, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1'b0, 31));
        vecs.push_back(mk("sll_zero",   OP_SLL, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk("mul",        OP_MUL, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, 1'b0, 1'b0, 32));
        vecs.push_back(mk("mul_ones",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32));
        vecs.push_back(mk("mul_zero",   OP_MUL, 32'h00000000, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b0, 32));
        vecs.push_back(mk("illegal10",  4'd10,  32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b0, 1'b1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Backpressure: result must hold while out_ready is low, then a pending OR goes back-to-back.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(mk("bp_and", OP_AND, 32'hC0000000, 32'hC000001F, 32'hC0000000, 1'b0, 1'b0, 1'b0, 0));
        checkOutput();
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_OR;
        a  = 32'hC00000FF;
        b  = 32'hF1E00000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkVal("bp held result", result, 32'hC0000000);
            checkBit("bp held out_valid", out_valid, 1'b1);
            checkBit("bp in_ready low", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        sb.push_back(toExp(mk("bp_or", OP_OR, 32'hC00000FF, 32'hF1E00000, 32'hF1E000FF, 1'b0, 1'b0, 1'b0, 0)));
        #1;
        checkBit("bp in_ready on release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput();

        // Asynchronous reset ten cycles into a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_MUL;
        a  = 32'h00012345;
        b  = 32'h00000100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkBit("async reset out_valid", out_valid, 1'b0);
        checkVal("async reset result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkBit("in_ready after mid-op reset", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkBit("no stale out_valid after reset", out_valid, 1'b0);
        applyStimulus(mk("illegal12", 4'd12, 32'hFFFF0000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 0));
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
